// File: rtl/apb_node_pkg.sv
// Shared types and constants for the cut APB node.
package apb_node_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Error response returned upstream: read data all zero, pslverr set.
  localparam logic ERR_PSLVERR    = 1'b1;
  localparam logic ERR_PRDATA_BIT = 1'b0;

  // Width of a port index; a single port still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_node_cut_if.sv
// Upstream, downstream and address-map signals of apb_node_cut.
interface apb_node_cut_if #(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32
);
  localparam int unsigned SW = APB_DATA_WIDTH / 8;

  // upstream
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [APB_DATA_WIDTH-1:0] pwdata_i;
  logic [SW-1:0]             pstrb_i;
  logic [APB_DATA_WIDTH-1:0] prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  // downstream
  logic [NB_MASTER-1:0]                     psel_o;
  logic [NB_MASTER-1:0]                     penable_o;
  logic [NB_MASTER-1:0]                     pwrite_o;
  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_o;
  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_o;
  logic [NB_MASTER-1:0][SW-1:0]             pstrb_o;
  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i;
  logic [NB_MASTER-1:0]                     pready_i;
  logic [NB_MASTER-1:0]                     pslverr_i;

  // address map (inclusive ranges)
  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i;
  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i;

  // node side
  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i,
    input  START_ADDR_i, END_ADDR_i
  );

  // environment side (upstream master, downstream slaves, map config)
  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i,
    output START_ADDR_i, END_ADDR_i
  );

endinterface

// File: rtl/apb_node_decode.sv
// Combinational address decoder: lowest-index inclusive range match wins.
module apb_node_decode
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned IDX_W          = idx_width(NB_MASTER)
) (
  input  logic [APB_ADDR_WIDTH-1:0]                 i_addr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]  i_start,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]  i_end,
  output logic                                      o_match_c,
  output logic [NB_MASTER-1:0]                      o_sel_c,
  output logic [IDX_W-1:0]                          o_idx_c
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    o_match_c = 1'b0;
    o_sel_c   = '0;
    o_idx_c   = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if ((i_start[i] <= i_addr) && (i_addr <= i_end[i])) begin
        o_match_c  = 1'b1;
        o_sel_c    = '0;
        o_sel_c[i] = 1'b1;
        o_idx_c    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_cut.sv
// APB 1-to-N node with a full register cut between upstream and downstream.
// Optional access-phase timeout enabled by defining APB_NODE_TIMEOUT_EN.
module apb_node_cut
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  apb_node_cut_if.slave bus
);

  localparam int unsigned SW    = APB_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = idx_width(NB_MASTER);

  // Elaboration-time parameter sanity checks.
  if (NB_MASTER < 1) begin : g_chk_nb
    $error("apb_node_cut: NB_MASTER must be >= 1");
  end
  if ((APB_DATA_WIDTH % 8) != 0) begin : g_chk_dw
    $error("apb_node_cut: APB_DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_to
    $error("apb_node_cut: TIMEOUT_CYCLES must be >= 1");
  end

  state_e                                   r_state;
  logic [IDX_W-1:0]                         r_idx;
  logic [NB_MASTER-1:0]                     r_psel;
  logic [NB_MASTER-1:0]                     r_penable;
  logic [NB_MASTER-1:0]                     r_pwrite;
  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] r_paddr;
  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] r_pwdata;
  logic [NB_MASTER-1:0][SW-1:0]             r_pstrb;
  logic [APB_DATA_WIDTH-1:0]                r_prdata;
  logic                                     r_pready;
  logic                                     r_pslverr;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOUT_W-1:0] r_tout;
`endif

  logic                 w_match;
  logic [NB_MASTER-1:0] w_sel;
  logic [IDX_W-1:0]     w_idx;

  apb_node_decode #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .IDX_W          (IDX_W)
  ) u_decode (
    .i_addr    (bus.paddr_i),
    .i_start   (bus.START_ADDR_i),
    .i_end     (bus.END_ADDR_i),
    .o_match_c (w_match),
    .o_sel_c   (w_sel),
    .o_idx_c   (w_idx)
  );

  // Transfer FSM; every output is a flop, response flops pulse for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_psel    <= '0;
      r_penable <= '0;
      r_pwrite  <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      r_tout    <= '0;
`endif
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.psel_i && !bus.penable_i) begin
            if (w_match) begin
              r_idx     <= w_idx;
              r_psel    <= w_sel;
              r_penable <= '0;
              for (int i = 0; i < NB_MASTER; i++) begin
                r_pwrite[i] <= w_sel[i] & bus.pwrite_i;
                r_paddr[i]  <= w_sel[i] ? bus.paddr_i  : '0;
                r_pwdata[i] <= w_sel[i] ? bus.pwdata_i : '0;
                r_pstrb[i]  <= w_sel[i] ? bus.pstrb_i  : '0;
              end
              r_state <= S_SETUP;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= ERR_PSLVERR;
              r_prdata  <= {APB_DATA_WIDTH{ERR_PRDATA_BIT}};
              r_state   <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= r_psel;
`ifdef APB_NODE_TIMEOUT_EN
          r_tout    <= '0;
`endif
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.pready_i[r_idx]) begin
            r_pready  <= 1'b1;
            r_pslverr <= bus.pslverr_i[r_idx];
            r_prdata  <= bus.pslverr_i[r_idx] ? {APB_DATA_WIDTH{ERR_PRDATA_BIT}}
                                              : bus.prdata_i[r_idx];
            r_psel    <= '0;
            r_penable <= '0;
            r_pwrite  <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_state   <= S_RESP;
          end
`ifdef APB_NODE_TIMEOUT_EN
          else if (r_tout == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
            // Last allowed wait cycle: abandon the slave and report an error.
            r_tout    <= r_tout + TOUT_W'(1);
            r_pready  <= 1'b1;
            r_pslverr <= ERR_PSLVERR;
            r_prdata  <= {APB_DATA_WIDTH{ERR_PRDATA_BIT}};
            r_psel    <= '0;
            r_penable <= '0;
            r_pwrite  <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_state   <= S_RESP;
          end else begin
            r_tout <= r_tout + TOUT_W'(1);
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.psel_o    = r_psel;
  assign bus.penable_o = r_penable;
  assign bus.pwrite_o  = r_pwrite;
  assign bus.paddr_o   = r_paddr;
  assign bus.pwdata_o  = r_pwdata;
  assign bus.pstrb_o   = r_pstrb;
  assign bus.prdata_o  = r_prdata;
  assign bus.pready_o  = r_pready;
  assign bus.pslverr_o = r_pslverr;

endmodule

// File: tb/tb_apb_node_cut.sv
// Scoreboard bench for apb_node_cut: stimulus pushes expected upstream
// responses, a monitor pops and compares whenever pready_o is seen.
module tb_apb_node_cut;

  localparam int unsigned NB = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  apb_node_cut_if #(.NB_MASTER(NB), .APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW)) bus();

  apb_node_cut #(
    .NB_MASTER      (NB),
    .APB_DATA_WIDTH (DW),
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(posedge clk) begin
    #1;
    if (bus.pready_o === 1'b1) begin
      chk("resp_expected", 256'(q.size() != 0), 256'(1));
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("resp_prdata",  256'(bus.prdata_o),  256'(e.rdata));
        chk("resp_pslverr", 256'(bus.pslverr_o), 256'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_up();
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = '0;
    bus.pwdata_i  = '0;
    bus.pstrb_i   = '0;
  endtask

  task automatic clear_slaves();
    bus.prdata_i  = '0;
    bus.pready_i  = '0;
    bus.pslverr_i = '0;
  endtask

  task automatic cfg_default();
    for (int i = 0; i < NB; i++) begin
      bus.START_ADDR_i[i] = '1;
      bus.END_ADDR_i[i]   = '0;
    end
    bus.START_ADDR_i[0] = 32'h0000_1000; bus.END_ADDR_i[0] = 32'h0000_1FFF;
    bus.START_ADDR_i[1] = 32'h0000_2000; bus.END_ADDR_i[1] = 32'h0000_2FFF;
    bus.START_ADDR_i[3] = 32'h0000_6000; bus.END_ADDR_i[3] = 32'h0000_5000;
    bus.START_ADDR_i[7] = 32'h0000_7000; bus.END_ADDR_i[7] = 32'h0000_70FF;
  endtask

  // One upstream transfer; port < 0 means no range should match.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input int port, input int waits, input logic [DW-1:0] rdata,
                         input logic serr, input bit glitch, input string tag);
    logic [NB-1:0]         oh;
    logic [NB-1:0][AW-1:0] ea;
    logic [NB-1:0][DW-1:0] ed;
    exp_t                  e;
    if (port < 0) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      e.rdata = serr ? '0 : rdata;
      e.err   = serr;
    end
    q.push_back(e);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = addr;
    bus.pwdata_i  = wdata;
    bus.pstrb_i   = wr ? 4'hF : 4'h0;
    tick();
    if (port < 0) begin
      chk({tag, "_no_psel"},   256'(bus.psel_o),   256'(0));
      chk({tag, "_pready_t1"}, 256'(bus.pready_o), 256'(1));
      clear_up();
      tick();
      return;
    end
    oh = NB'(1) << port;
    ea = '0;
    ea[port] = addr;
    ed = '0;
    ed[port] = wdata;
    chk({tag, "_psel_t1"},    256'(bus.psel_o),    256'(oh));
    chk({tag, "_penable_t1"}, 256'(bus.penable_o), 256'(0));
    chk({tag, "_paddr_t1"},   256'(bus.paddr_o),   256'(ea));
    chk({tag, "_pwdata_t1"},  256'(bus.pwdata_o),  256'(ed));
    chk({tag, "_pwrite_t1"},  256'(bus.pwrite_o),  256'(wr ? oh : '0));
    if (glitch) begin
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
      bus.paddr_i   = '1;
      bus.pwrite_i  = ~wr;
    end else begin
      bus.penable_i = 1'b1;
    end
    tick();
    chk({tag, "_penable_t2"}, 256'(bus.penable_o), 256'(oh));
    chk({tag, "_paddr_t2"},   256'(bus.paddr_o),   256'(ea));
    chk({tag, "_pready_t2"},  256'(bus.pready_o),  256'(0));
    for (int w = 0; w < waits; w++) tick();
    bus.pready_i       = oh;
    bus.prdata_i[port] = rdata;
    bus.pslverr_i      = serr ? oh : '0;
    tick();
    chk({tag, "_pready_resp"}, 256'(bus.pready_o), 256'(1));
    chk({tag, "_psel_drop"},   256'(bus.psel_o),   256'(0));
    clear_slaves();
    clear_up();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    clear_up();
    clear_slaves();
    cfg_default();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel",    256'(bus.psel_o),    256'(0));
    chk("rst_penable", 256'(bus.penable_o), 256'(0));
    chk("rst_paddr",   256'(bus.paddr_o),   256'(0));
    chk("rst_pready",  256'(bus.pready_o),  256'(0));
    chk("rst_pslverr", 256'(bus.pslverr_o), 256'(0));
    chk("rst_prdata",  256'(bus.prdata_o),  256'(0));
    rst = 1'b0;
    tick();

    do_xfer(32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 1, 0, 32'h0,         1'b0, 1'b0, "wr2004");
    do_xfer(32'h0000_1010, 1'b0, 32'h0,        0, 3, 32'h1234_5678, 1'b0, 1'b0, "rd1010");
    do_xfer(32'h0000_5000, 1'b0, 32'h0,       -1, 0, 32'h0,         1'b0, 1'b0, "rd5000");
    chk("idle_prdata", 256'(bus.prdata_o), 256'(0));
    do_xfer(32'h0000_1FFF, 1'b0, 32'h0,        0, 0, 32'hA5A5_0001, 1'b0, 1'b0, "top0");
    do_xfer(32'h0000_2000, 1'b0, 32'h0,        1, 1, 32'h0BAD_F00D, 1'b0, 1'b0, "bot1");
    do_xfer(32'h0000_0FFF, 1'b0, 32'h0,       -1, 0, 32'h0,         1'b0, 1'b0, "below0");
    do_xfer(32'h0000_70FF, 1'b1, 32'h0000_0077, 7, 0, 32'h0000_0007, 1'b0, 1'b0, "top7");
    do_xfer(32'h0000_7100, 1'b0, 32'h0,       -1, 0, 32'h0,         1'b0, 1'b0, "above7");
    do_xfer(32'h0000_5800, 1'b0, 32'h0,       -1, 0, 32'h0,         1'b0, 1'b0, "inverted3");
    do_xfer(32'h0000_2010, 1'b1, 32'h0000_0001, 1, 2, 32'hFFFF_FFFF, 1'b1, 1'b0, "slverr");
    do_xfer(32'h0000_1020, 1'b0, 32'h0,        0, 2, 32'hCAFE_0001, 1'b0, 1'b1, "glitch");

    bus.START_ADDR_i[0] = 32'h0000_1000; bus.END_ADDR_i[0] = 32'h0000_3FFF;
    bus.START_ADDR_i[2] = 32'h0000_3000; bus.END_ADDR_i[2] = 32'h0000_3FFF;
    do_xfer(32'h0000_3000, 1'b0, 32'h0,        0, 0, 32'h3333_0000, 1'b0, 1'b0, "overlap");
    cfg_default();

`ifdef APB_NODE_TIMEOUT_EN
    // Slave never answers: four access cycles, then an error response.
    e.rdata = '0;
    e.err   = 1'b1;
    q.push_back(e);
    bus.psel_i  = 1'b1;
    bus.paddr_i = 32'h0000_1040;
    tick();
    bus.penable_i = 1'b1;
    tick();
    chk("tout_psel_a1",   256'(bus.psel_o),   256'(1));
    tick();
    tick();
    tick();
    chk("tout_psel_a4",   256'(bus.psel_o),   256'(1));
    chk("tout_pready_a4", 256'(bus.pready_o), 256'(0));
    tick();
    chk("tout_psel_drop", 256'(bus.psel_o),    256'(0));
    chk("tout_pen_drop",  256'(bus.penable_o), 256'(0));
    chk("tout_pready",    256'(bus.pready_o),  256'(1));
    clear_up();
    tick();
`endif

    // Park a transfer in ACCESS, then reset asynchronously mid-cycle.
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = 32'h0000_1040;
    tick();
    bus.penable_i = 1'b1;
    tick();
`ifdef APB_NODE_TIMEOUT_EN
    tick();
`else
    repeat (20) tick();
    chk("hang_pready", 256'(bus.pready_o), 256'(0));
`endif
    chk("access_psel",    256'(bus.psel_o),    256'(1));
    chk("access_penable", 256'(bus.penable_o), 256'(1));
    rst = 1'b1;
    #1;
    chk("arst_psel",    256'(bus.psel_o),    256'(0));
    chk("arst_penable", 256'(bus.penable_o), 256'(0));
    chk("arst_paddr",   256'(bus.paddr_o),   256'(0));
    chk("arst_pready",  256'(bus.pready_o),  256'(0));
    clear_up();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    do_xfer(32'h0000_2008, 1'b0, 32'h0, 1, 1, 32'h5555_AAAA, 1'b0, 1'b0, "post_rst");

    repeat (3) tick();
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
